ad9959_cmd_arb: RTL and testbench
=================================

AD9959_CMD_ARB -- requirements
Module: ad9959_cmd_arb

Interface
REQ-001 Parameter TIMEOUT, default 16'd50000: max cycles waited for dds_ready_i to return high after a trigger.
REQ-002 Parameter ACK_WIN, default 8: max cycles waited for dds_ready_i to drop after a trigger.
REQ-003 Parameter HOST_PRIO, default 0: 0 = round-robin, 1 = host fixed priority.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 clk_i  in  1  system clock, all logic on its rising edge.
REQ-006 reset_n_i  in  1  asynchronous active-low reset.
REQ-007 h_req_i  in  1  host request, level, held until h_ack_o.
REQ-008 h_cmd_i / h_sel_i / h_data_i  in  5/4/32  host command, channel select, data.
REQ-009 h_ack_o  out  1  one-cycle pulse, host payload latched.
REQ-010 h_done_o  out  1  one-cycle pulse, host command finished.
REQ-011 s_req_i, s_cmd_i, s_sel_i, s_data_i, s_ack_o, s_done_o: sequencer port, same widths and meaning as host.
REQ-012 dds_cmd_o / dds_sel_o / dds_data_o  out  5/4/32  to DDS controller cmd_i/sel_i/data_i.
REQ-013 dds_trig_o  out  1  one-cycle command strobe to DDS controller cmdtrig_i.
REQ-014 dds_ready_i  in  1  DDS controller ready_o.
REQ-015 busy_o  out  1  high whenever state is not IDLE.
REQ-016 timeout_o  out  1  sticky error flag; err_clr_i  in  1  clears it.

Function
REQ-017 States SHALL be IDLE, ISSUE, WAIT_LO, WAIT_HI, DONE.
REQ-018 IDLE: with dds_ready_i=1 and any req high, SHALL pick a winner, register its cmd/sel/data onto dds_*_o, pulse its ack, and go to ISSUE; with dds_ready_i=0 no grant.
REQ-019 Arbitration: single request wins; on a tie with HOST_PRIO=0 the requester not granted last wins; with HOST_PRIO=1 host wins.
REQ-020 ISSUE: dds_trig_o=1 for exactly this one cycle; then WAIT_LO.
REQ-021 WAIT_LO: dds_ready_i=0 -> WAIT_HI; ACK_WIN cycles elapsed with ready still high -> DONE, no error.
REQ-022 WAIT_HI: dds_ready_i=1 -> DONE; TIMEOUT cycles elapsed -> set timeout_o, go DONE.
REQ-023 DONE: pulse owner's done_o once, record owner as last-granted, go IDLE.
REQ-024 Wait counter SHALL be 16-bit, cleared on every state entry, saturating, never wrapping.
REQ-025 Minimum spacing: trigger-to-trigger SHALL be at least 4 cycles (ISSUE, WAIT_LO, WAIT_HI/DONE, IDLE).
REQ-026 dds_cmd_o/sel_o/data_o SHALL hold the last granted payload until the next grant.
REQ-027 Requests arriving outside IDLE SHALL wait; payload changes before ack are not seen.
REQ-028 Dropping req before ack SHALL withdraw the request without side effect.
REQ-029 err_clr_i and a timeout set in the same cycle: set wins.

Reset
REQ-030 reset_n_i low SHALL immediately force IDLE, all outputs 0, timeout_o 0, counter 0, last-granted = sequencer, so the host wins the first tie.
REQ-031 Reset mid-command SHALL abort without a done_o pulse; the first grant after release requires dds_ready_i=1.

Verification
REQ-032 Host only, cmd=5'h2, sel=4'h1, data=12345678, DDS model drops ready 1 cycle after trig and raises it 20 cycles later -> one h_ack_o, one dds_trig_o with those values, one h_done_o, timeout_o=0.
REQ-033 Both request at once after reset, HOST_PRIO=0, both held -> grants alternate host, seq, host, seq; no grant while busy_o=1.
REQ-034 HOST_PRIO=1, both held for 3 commands -> host granted 3 times, seq never.
REQ-035 DDS model never raises ready after trig, TIMEOUT=100 -> timeout_o set 100 cycles into WAIT_HI, done_o pulses, err_clr_i clears it.
REQ-036 DDS model keeps ready high, ACK_WIN=8 -> done_o 8 cycles after WAIT_LO entry, no error.
REQ-037 Reset asserted during WAIT_HI -> all outputs 0 asynchronously, no done_o; after release host tie-win rule holds.

Source files
------------

// File: rtl/ad9959_cmd_arb.sv
// rtl/ad9959_cmd_arb.sv - two-port command arbiter in front of an AD9959 DDS controller
`timescale 1ns/1ps

module ad9959_cmd_arb #(
  parameter logic [15:0] TIMEOUT   = 16'd50000,
  parameter int unsigned ACK_WIN   = 8,
  parameter bit          HOST_PRIO = 1'b0
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  // host port
  input  logic        h_req_i,
  input  logic [4:0]  h_cmd_i,
  input  logic [3:0]  h_sel_i,
  input  logic [31:0] h_data_i,
  output logic        h_ack_o,
  output logic        h_done_o,
  // sequencer port
  input  logic        s_req_i,
  input  logic [4:0]  s_cmd_i,
  input  logic [3:0]  s_sel_i,
  input  logic [31:0] s_data_i,
  output logic        s_ack_o,
  output logic        s_done_o,
  // DDS controller side
  output logic [4:0]  dds_cmd_o,
  output logic [3:0]  dds_sel_o,
  output logic [31:0] dds_data_o,
  output logic        dds_trig_o,
  input  logic        dds_ready_i,
  // status
  output logic        busy_o,
  output logic        timeout_o,
  input  logic        err_clr_i
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT_LO = 3'd2,
    WAIT_HI = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [16:0] ACK_LIM = 17'(ACK_WIN);
  localparam logic [16:0] TO_LIM  = {1'b0, TIMEOUT};

  state_t      state;
  logic [15:0] wait_cnt;
  logic        owner;      // 0 = host, 1 = sequencer
  logic        last_seq;   // last completed grant went to the sequencer

  logic        any_req;
  logic        pick_seq;
  logic [16:0] cnt_inc;
  logic [15:0] cnt_sat;
  logic        ack_hit;
  logic        to_hit;
  logic        to_set;

  assign any_req = h_req_i | s_req_i;
  assign cnt_inc = {1'b0, wait_cnt} + 17'd1;
  assign cnt_sat = (wait_cnt == 16'hFFFF) ? wait_cnt : wait_cnt + 16'd1;
  // a window of N cycles has elapsed when the cycle about to end is the Nth
  assign ack_hit = (cnt_inc >= ACK_LIM);
  assign to_hit  = (cnt_inc >= TO_LIM);
  assign to_set  = (state == WAIT_HI) && !dds_ready_i && to_hit;

  // winner selection: lone requester wins; ties go by priority mode
  always_comb begin
    pick_seq = 1'b0;
    if (h_req_i && s_req_i) begin
      pick_seq = HOST_PRIO ? 1'b0 : ~last_seq;
    end else begin
      pick_seq = s_req_i;
    end
  end

  // command FSM with registered handshake, strobe and status outputs
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state      <= IDLE;
      wait_cnt   <= 16'd0;
      owner      <= 1'b0;
      last_seq   <= 1'b1;
      h_ack_o    <= 1'b0;
      s_ack_o    <= 1'b0;
      h_done_o   <= 1'b0;
      s_done_o   <= 1'b0;
      dds_cmd_o  <= 5'd0;
      dds_sel_o  <= 4'd0;
      dds_data_o <= 32'd0;
      dds_trig_o <= 1'b0;
      busy_o     <= 1'b0;
      timeout_o  <= 1'b0;
    end else begin
      h_ack_o    <= 1'b0;
      s_ack_o    <= 1'b0;
      h_done_o   <= 1'b0;
      s_done_o   <= 1'b0;
      dds_trig_o <= 1'b0;

      // a timeout raised this cycle beats a simultaneous clear
      if (to_set) begin
        timeout_o <= 1'b1;
      end else if (err_clr_i) begin
        timeout_o <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (dds_ready_i && any_req) begin
            owner      <= pick_seq;
            dds_cmd_o  <= pick_seq ? s_cmd_i  : h_cmd_i;
            dds_sel_o  <= pick_seq ? s_sel_i  : h_sel_i;
            dds_data_o <= pick_seq ? s_data_i : h_data_i;
            h_ack_o    <= ~pick_seq;
            s_ack_o    <= pick_seq;
            dds_trig_o <= 1'b1;
            busy_o     <= 1'b1;
            wait_cnt   <= 16'd0;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt <= 16'd0;
          state    <= WAIT_LO;
        end
        WAIT_LO: begin
          if (!dds_ready_i) begin
            wait_cnt <= 16'd0;
            state    <= WAIT_HI;
          end else if (ack_hit) begin
            // controller never acknowledged; treat the command as taken
            wait_cnt <= 16'd0;
            h_done_o <= ~owner;
            s_done_o <= owner;
            state    <= DONE;
          end else begin
            wait_cnt <= cnt_sat;
          end
        end
        WAIT_HI: begin
          if (dds_ready_i || to_hit) begin
            wait_cnt <= 16'd0;
            h_done_o <= ~owner;
            s_done_o <= owner;
            state    <= DONE;
          end else begin
            wait_cnt <= cnt_sat;
          end
        end
        DONE: begin
          last_seq <= owner;
          wait_cnt <= 16'd0;
          busy_o   <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          wait_cnt <= 16'd0;
          busy_o   <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ad9959_cmd_arb.sv
// tb/tb_ad9959_cmd_arb.sv - self-checking bench for ad9959_cmd_arb
`timescale 1ns/1ps

module tb_ad9959_cmd_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        h_req, s_req;
  logic [4:0]  h_cmd, s_cmd;
  logic [3:0]  h_sel, s_sel;
  logic [31:0] h_data, s_data;
  logic        dds_ready;
  logic        err_clr;

  logic        h_ack_a, h_done_a, s_ack_a, s_done_a, trig_a, busy_a, timeout_a;
  logic [4:0]  cmd_a;
  logic [3:0]  sel_a;
  logic [31:0] data_a;
  logic        h_ack_b, h_done_b, s_ack_b, s_done_b, trig_b, busy_b, timeout_b;
  logic [4:0]  cmd_b;
  logic [3:0]  sel_b;
  logic [31:0] data_b;

  ad9959_cmd_arb #(.TIMEOUT(16'd100), .ACK_WIN(8), .HOST_PRIO(1'b0)) dut_a (
    .clk_i(clk), .reset_n_i(reset_n),
    .h_req_i(h_req), .h_cmd_i(h_cmd), .h_sel_i(h_sel), .h_data_i(h_data),
    .h_ack_o(h_ack_a), .h_done_o(h_done_a),
    .s_req_i(s_req), .s_cmd_i(s_cmd), .s_sel_i(s_sel), .s_data_i(s_data),
    .s_ack_o(s_ack_a), .s_done_o(s_done_a),
    .dds_cmd_o(cmd_a), .dds_sel_o(sel_a), .dds_data_o(data_a),
    .dds_trig_o(trig_a), .dds_ready_i(dds_ready),
    .busy_o(busy_a), .timeout_o(timeout_a), .err_clr_i(err_clr)
  );

  ad9959_cmd_arb #(.TIMEOUT(16'd100), .ACK_WIN(8), .HOST_PRIO(1'b1)) dut_b (
    .clk_i(clk), .reset_n_i(reset_n),
    .h_req_i(h_req), .h_cmd_i(h_cmd), .h_sel_i(h_sel), .h_data_i(h_data),
    .h_ack_o(h_ack_b), .h_done_o(h_done_b),
    .s_req_i(s_req), .s_cmd_i(s_cmd), .s_sel_i(s_sel), .s_data_i(s_data),
    .s_ack_o(s_ack_b), .s_done_o(s_done_b),
    .dds_cmd_o(cmd_b), .dds_sel_o(sel_b), .dds_data_o(data_b),
    .dds_trig_o(trig_b), .dds_ready_i(dds_ready),
    .busy_o(busy_b), .timeout_o(timeout_b), .err_clr_i(err_clr)
  );

  // DDS controller behaviour
  typedef enum int {M_NORMAL, M_NEVER, M_HI, M_LO} mode_t;
  mode_t mode     = M_HI;
  int    hi_delay = 20;

  initial begin
    int k;
    k = 0;
    dds_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (mode)
        M_HI: dds_ready = 1'b1;
        M_LO: dds_ready = 1'b0;
        default: begin
          if (trig_a) begin
            dds_ready = 1'b0;
            k = hi_delay;
          end else if (k > 0) begin
            k = k - 1;
            if (k == 0 && mode == M_NORMAL) dds_ready = 1'b1;
          end
        end
      endcase
    end
  end

  // pulse counters, sampled on the edge that ends each cycle
  int ha_a = 0, sa_a = 0, hd_a = 0, sd_a = 0, ha_b = 0, sa_b = 0;
  always @(posedge clk) begin
    if (h_ack_a)  ha_a <= ha_a + 1;
    if (s_ack_a)  sa_a <= sa_a + 1;
    if (h_done_a) hd_a <= hd_a + 1;
    if (s_done_a) sd_a <= sd_a + 1;
    if (h_ack_b)  ha_b <= ha_b + 1;
    if (s_ack_b)  sa_b <= sa_b + 1;
  end

  int n_cmp  = 0;
  int n_fail = 0;
  bit model_last_seq = 1'b1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // reference arbitration: lone request wins, tie goes to whoever was not served last
  function automatic bit model_pick_seq(input bit hr, input bit sr);
    if (hr && sr) return !model_last_seq;
    return sr;
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    h_req   = 1'b0;
    s_req   = 1'b0;
    err_clr = 1'b0;
    tick(3);
    check("rst.ctl_a", {h_ack_a, s_ack_a, h_done_a, s_done_a, trig_a, busy_a, timeout_a}, 0);
    check("rst.pay_a", {cmd_a, sel_a, data_a}, 0);
    check("rst.ctl_b", {h_ack_b, s_ack_b, h_done_b, s_done_b, trig_b, busy_b, timeout_b}, 0);
    check("rst.pay_b", {cmd_b, sel_b, data_b}, 0);
    reset_n = 1'b1;
    model_last_seq = 1'b1;
    tick(1);
  endtask

  task automatic wait_ack(output bit got, output logic prev_busy);
    got = 1'b0;
    prev_busy = busy_a;
    for (int i = 0; i < 60 && !got; i++) begin
      tick();
      if (h_ack_a || s_ack_a) got = 1'b1;
      else prev_busy = busy_a;
    end
  endtask

  // one full command on dut_a, checked against the reference timing
  task automatic issue(input string tag, input bit drop, input int exp_lat, input bit exp_to);
    bit          want_seq, got;
    logic        prev_busy;
    int          lat;
    logic [40:0] exp_pay;
    want_seq = model_pick_seq(h_req, s_req);
    exp_pay  = want_seq ? {s_cmd, s_sel, s_data} : {h_cmd, h_sel, h_data};
    wait_ack(got, prev_busy);
    check({tag, ".ack_seen"}, got, 1);
    if (!got) return;
    check({tag, ".ack_owner"}, {h_ack_a, s_ack_a}, want_seq ? 2'b01 : 2'b10);
    check({tag, ".trig"}, trig_a, 1);
    check({tag, ".idle_before"}, prev_busy, 0);
    check({tag, ".payload"}, {cmd_a, sel_a, data_a}, exp_pay);
    if (drop) begin
      h_req = 1'b0;
      s_req = 1'b0;
    end
    lat = 0;
    for (int i = 1; i <= 300 && lat == 0; i++) begin
      tick();
      if (h_done_a || s_done_a) lat = i;
    end
    check({tag, ".latency"}, lat, exp_lat);
    check({tag, ".done_owner"}, {h_done_a, s_done_a}, want_seq ? 2'b01 : 2'b10);
    check({tag, ".timeout"}, timeout_a, exp_to);
    check({tag, ".held"}, {cmd_a, sel_a, data_a}, exp_pay);
    model_last_seq = want_seq;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   snap_h, snap_s, snap_d, trials;
    bit   got;
    logic pb;
    reset_n = 1'b0;
    h_req = 0; s_req = 0; err_clr = 0;
    h_cmd = 0; h_sel = 0; h_data = 0;
    s_cmd = 0; s_sel = 0; s_data = 0;
    do_reset();

    // single host command with a well-behaved controller
    mode = M_NORMAL; hi_delay = 20;
    h_cmd = 5'h2; h_sel = 4'h1; h_data = 32'h12345678; h_req = 1'b1;
    snap_h = ha_a + sa_a;
    issue("host_only", 1'b1, 21, 1'b0);
    tick(2);
    check("host_only.n_acks", ha_a + sa_a - snap_h, 1);

    // both held: round-robin on dut_a, host priority on dut_b
    do_reset();
    mode = M_HI;
    h_cmd = 5'h03; h_sel = 4'h2; h_data = 32'hA5A5_0001;
    s_cmd = 5'h11; s_sel = 4'h8; s_data = 32'h5A5A_0002;
    snap_h = ha_b; snap_s = sa_b;
    h_req = 1'b1; s_req = 1'b1;
    issue("rr0", 1'b0, 9, 1'b0);
    issue("rr1", 1'b0, 9, 1'b0);
    issue("rr2", 1'b0, 9, 1'b0);
    issue("rr3", 1'b1, 9, 1'b0);
    tick(2);
    check("prio.host_grants", ha_b - snap_h, 4);
    check("prio.seq_grants", sa_b - snap_s, 0);
    check("prio.payload", data_b, 32'hA5A5_0001);

    // no grant while the controller reports not ready
    mode = M_LO;
    tick(1);
    snap_h = ha_a + sa_a;
    h_req = 1'b1;
    tick(10);
    check("not_ready.no_grant", ha_a + sa_a - snap_h, 0);
    mode = M_HI;
    issue("not_ready.release", 1'b1, 9, 1'b0);

    // controller never returns ready: timeout, sticky flag, clear
    mode = M_NEVER;
    h_req = 1'b1;
    issue("timeout", 1'b1, 102, 1'b1);
    mode = M_HI;
    tick(2);
    check("timeout.sticky", timeout_a, 1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("timeout.cleared", timeout_a, 0);

    // clear held across a new timeout: the set wins
    mode = M_NEVER;
    err_clr = 1'b1;
    s_req = 1'b1;
    issue("to_vs_clr", 1'b1, 102, 1'b1);
    mode = M_HI;
    tick(1);
    check("to_vs_clr.after", timeout_a, 0);
    err_clr = 1'b0;

    // controller never drops ready: give up after the ack window
    s_req = 1'b1;
    issue("ack_win", 1'b1, 9, 1'b0);

    // reset in the middle of WAIT_HI
    mode = M_NORMAL; hi_delay = 30;
    h_req = 1'b1;
    wait_ack(got, pb);
    check("mid_rst.ack", got, 1);
    h_req = 1'b0;
    tick(5);
    check("mid_rst.busy", busy_a, 1);
    snap_d = hd_a + sd_a;
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst.async_ctl", {h_ack_a, s_ack_a, h_done_a, s_done_a, trig_a, busy_a, timeout_a}, 0);
    check("mid_rst.async_pay", {cmd_a, sel_a, data_a}, 0);
    mode = M_HI;
    tick(3);
    reset_n = 1'b1;
    model_last_seq = 1'b1;
    tick(4);
    check("mid_rst.no_done", hd_a + sd_a - snap_d, 0);
    h_cmd = 5'h1F; h_sel = 4'hF; h_data = 32'hDEAD_BEEF;
    s_cmd = 5'h01; s_sel = 4'h3; s_data = 32'h0BAD_F00D;
    h_req = 1'b1; s_req = 1'b1;
    issue("mid_rst.first_tie", 1'b1, 9, 1'b0);

    // randomized commands against the reference model
    mode = M_NORMAL;
    trials = 20;
    snap_h = ha_a + sa_a;
    for (int t = 0; t < trials; t++) begin
      int r;
      r = $urandom_range(1, 3);
      hi_delay = $urandom_range(2, 30);
      h_cmd  = 5'($urandom); h_sel = 4'($urandom); h_data = $urandom;
      s_cmd  = 5'($urandom); s_sel = 4'($urandom); s_data = $urandom;
      h_req  = r[0];
      s_req  = r[1];
      issue($sformatf("rand%0d", t), 1'b1, hi_delay + 1, 1'b0);
    end
    tick(5);
    check("rand.grant_count", ha_a + sa_a - snap_h, trials);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
